return_stack: RTL

- Call/return unit that drives the program counter's load/address interface.
- On a call it pushes the current counter value onto a LIFO and redirects the PC to the call target.
- On a return it pops the saved value and redirects the PC to it. Under the PC's load convention, execution resumes at popped value + 1, the instruction after the call.
- Sits between the instruction decoder (call/ret strobes) and the program counter.

---
 rtl/return_stack.sv | 127 ++++++++++++
 1 files changed

// File: rtl/return_stack.sv
// Call/return unit: pushes the PC on call, pops it on return, and drives a one-cycle load pulse to the PC.
// Optional RETURN_STACK_WRAP_EN: a call while full overwrites the oldest entry instead of being rejected.
module return_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     call,
    input  logic                     ret,
    input  logic [WIDTH-1:0]         target,
    input  logic [WIDTH-1:0]         counter,
    output logic                     ready,
    output logic                     load,
    output logic [WIDTH-1:0]         address,
    output logic                     notUpdate,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     empty,
    output logic                     full,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_MAX = (AW+1)'(DEPTH);

`ifdef RETURN_STACK_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ISSUE, SETTLE} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    ptr;
    logic [AW-1:0]    ptr_prev;
    logic             push;
    logic             pop;
    logic             reject_call;
    logic             reject_ret;
    logic             load_next;
    logic             not_update_next;

    assign empty    = (depth == '0);
    assign full     = (depth == DEPTH_MAX);
    assign ptr_prev = ptr - AW'(1);

    // Request decode: call wins over ret; requests outside IDLE are ignored.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        push        = 1'b0;
        pop         = 1'b0;
        reject_call = 1'b0;
        reject_ret  = 1'b0;
        if (state == IDLE) begin
            if (call) begin
                if (!full || WRAP) push = 1'b1;
                else               reject_call = 1'b1;
            end else if (ret) begin
                if (!empty) pop = 1'b1;
                else        reject_ret = 1'b1;
            end
        end
    end

    // State register, plus the registered PC-facing strobes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            load      <= 1'b0;
            notUpdate <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state     <= state_next;
            load      <= load_next;
            notUpdate <= not_update_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (push || pop) state_next = ISSUE;
            ISSUE:   state_next = SETTLE;
            SETTLE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // load is high only in ISSUE; notUpdate covers ISSUE and SETTLE.
    always_comb begin
        ready           = (state == IDLE);
        load_next       = push || pop;
        not_update_next = push || pop || (state == ISSUE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr       <= '0;
            depth     <= '0;
            address   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push) begin
                ptr     <= ptr + AW'(1);
                address <= target;
                if (!full) depth <= depth + (AW+1)'(1);
            end else if (pop) begin
                ptr     <= ptr_prev;
                address <= mem[ptr_prev];
                depth   <= depth - (AW+1)'(1);
            end
            if (reject_call) overflow  <= 1'b1;
            if (reject_ret)  underflow <= 1'b1;
        end
    end

    // NOTE: the stack RAM is deliberately not reset; depth alone defines which entries are valid.
    always_ff @(posedge clock) begin
        if (push) mem[ptr] <= counter;
    end

endmodule
